md5_hasher_mul_pipe: RTL
========================

# md5_hasher_mul_pipe

Parametrised pipelined multiplier for the MD5 hasher datapath. It computes the product of two operands whose width and signedness are set per instance, and its depth is configurable. A valid bit travels alongside the data, and `ce` stalls the whole pipeline. It replaces the fixed 16×16 unsigned-by-signed DSP48 multiplier instances used for message-index and round-constant arithmetic, and it can optionally act as a multiply-accumulate unit.

## Interface
- `A_WIDTH`, default 16: width of `din0`; range 2–32.
- `B_WIDTH`, default 16: width of `din1`; range 2–32.
- `P_WIDTH`, default 32: width of `dout`; range 2–64.
- `A_SIGNED`, default 0: 1 means `din0` is two's complement; 0 means unsigned.
- `B_SIGNED`, default 1: 1 means `din1` is two's complement; 0 means unsigned.
- `NUM_STAGE`, default 3: register stages from input to `dout`; range 2–6.
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ce`  in  1  clock enable; when low, every register in the block holds.
- `in_valid`  in  1  `din0`/`din1` carry an operand pair this cycle.
- `din0`  in  `A_WIDTH`  operand A.
- `din1`  in  `B_WIDTH`  operand B.
- `out_valid`  out  1  `dout` holds a result; high for exactly one `ce`-high cycle per result.
- `dout`  out  `P_WIDTH`  product, or the accumulator value (see Configuration).
- One clock; reset is synchronous and active-high.

## Operation
- Each operand is extended by one bit according to its signedness: zero-extended if unsigned, sign-extended if signed.
- The two extended operands are multiplied as signed values. The full product width is `A_WIDTH+B_WIDTH+2`.
- The result is fitted to `P_WIDTH`:
  - if `P_WIDTH` is smaller than the full width, keep the low `P_WIDTH` bits (wrap);
  - if larger, sign-extend.
- Stage 1 registers `din0`, `din1` and `in_valid`.
- Stage 2 registers the product.
- Stages 3 to `NUM_STAGE` are pure delay registers, so the synthesis tool can retime them into the DSP.
- `in_valid` travels through a parallel shift register of length `NUM_STAGE`.
- Data registers load on every `ce`-high cycle, whatever the value of `in_valid`.
- `dout` is meaningful only while `out_valid` = 1.
- Reset:
  - clears every valid bit, all data registers, `dout` and the accumulator to 0;
  - takes priority over `ce`;
  - when asserted mid-operation, discards all in-flight results; no `out_valid` appears for any pair accepted before reset.

## Timing
- Latency: a pair accepted on `ce`-high cycle N appears on `dout` with `out_valid` = 1 after exactly `NUM_STAGE` `ce`-high edges. Cycles with `ce` low do not count.
- Throughput: one pair per `ce`-high cycle; there is no backpressure apart from `ce`.
- When `ce` is low, `dout` and `out_valid` hold their values. A pending `out_valid` = 1 therefore remains visible for the whole stall.
- `in_valid` is ignored in any cycle where `ce` = 0.
- Reset values: `out_valid` = 0 and `dout` = 0, starting on the first edge at which `reset` is sampled high.

## Configuration
- Macro: `MD5_HASHER_MUL_ACC_EN`.
- Defined:
  - two extra ports are added, `acc_en` (in, 1 bit) and `acc_clr` (in, 1 bit);
  - both are sampled with the operands and travel with the valid bit;
  - one accumulator stage of `P_WIDTH` bits is appended, so latency becomes `NUM_STAGE+1`.
- Accumulator update, on a valid result with `ce` high:
  - `acc <= acc_en ? (acc_clr ? 0 : acc) + prod : prod`;
  - the sum wraps modulo 2^`P_WIDTH`.
- On an invalid slot the accumulator holds. `dout` is the accumulator register.
- Undefined: the ports and the accumulator stage are absent, and the block behaves as a pure multiplier.

## Structure
- Shared package `md5_hasher_mul_pkg` holds:
  - constants `MUL_MIN_STAGE` = 2 and `MUL_MAX_STAGE` = 6;
  - a function returning the full product width from the two operand widths.
- Sub-module `md5_hasher_delay_line`: a parametrised width/depth shift register with `ce` and synchronous clear. It implements the valid chain and the post-product delay stages.
- Elaboration-time check: `NUM_STAGE` must lie within [`MUL_MIN_STAGE`, `MUL_MAX_STAGE`]; any other value is a fatal error.

## Test plan
- Default parameters, `din0` = 0xFFFF, `din1` = 0xFFFF (i.e. −1), `in_valid` = 1 for one cycle, `ce` = 1 → 3 cycles later `dout` = 0xFFFF0001 and `out_valid` = 1 for one cycle only.
- `A_SIGNED` = 1, `B_SIGNED` = 1, operands 0x8000 × 0x8000 → `dout` = 0x40000000. With `P_WIDTH` = 16, the same inputs give `dout` = 0x0000 (wrap).
- Back-to-back pairs 2×3, 4×5, 6×7, with `ce` forced low for 2 cycles after the second pair → outputs 6, 20, 42 in order, each with one `out_valid`; the total `ce`-high latency of each result is still 3.
- `NUM_STAGE` = 5, pair 100×7, `reset` asserted for one cycle at cycle 2 → no `out_valid` follows; `dout` = 0 from the reset edge onward. A pair 9×9 sent after reset returns 81 five cycles later.
- With `MD5_HASHER_MUL_ACC_EN` defined: 3×4 (`acc_en` = 1, `acc_clr` = 1), then 5×6 (`acc_en` = 1, `acc_clr` = 0), then 2×2 (`acc_en` = 0) → `dout` sequence 12, 42, 4 at latency 4.
- Random stimulus under all four signedness combinations, with `ce` and `in_valid` toggled randomly → every `dout` matches a reference model and the count of `out_valid` pulses equals the count of accepted inputs.

Source files
------------

// File: rtl/md5_hasher_mul_pkg.sv
// Shared constants and helpers for the MD5 hasher pipelined multiplier.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package md5_hasher_mul_pkg;

    localparam int MUL_MIN_STAGE = 2;
    localparam int MUL_MAX_STAGE = 6;

    // Each operand gains one extension bit, so the exact signed product of
    // the two extended operands needs the sum of both widths plus two.
    function automatic int mul_full_width(input int a_width, input int b_width);
        return a_width + b_width + 2;
    endfunction

endpackage

// File: rtl/md5_hasher_delay_line.sv
// Parametrised width/depth shift register with clock enable and sync clear.
// Latency: DEPTH enabled clock edges from din to dout.
// Backpressure: none; every stage holds while ce is low.
//
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high clear of every stage
//   ce    - clock enable; all stages hold when low
//   din   - data entering stage 0
//   dout  - data leaving the last stage
module md5_hasher_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] sr_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                sr_q[i] <= '0;
            end
        end else if (ce) begin
            sr_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/md5_hasher_mul_pipe.sv
// Pipelined multiplier with per-operand signedness; optional multiply-accumulate.
// Latency: NUM_STAGE ce-high edges (NUM_STAGE+1 with MD5_HASHER_MUL_ACC_EN).
// Backpressure: none; ce low freezes every register, including the outputs.
//
// Optional feature macro: MD5_HASHER_MUL_ACC_EN (adds acc_en/acc_clr and an
// accumulator stage that drives dout).
//
// Ports:
//   clk, reset         - clock, synchronous active-high reset
//   ce                 - clock enable for the whole pipeline
//   in_valid/din0/din1 - operand pair, accepted when in_valid and ce are high
//   acc_en/acc_clr     - (macro only) accumulate / restart-accumulate controls
//   out_valid/dout     - result strobe and product (or accumulator value)
module md5_hasher_mul_pipe
    import md5_hasher_mul_pkg::*;
#(
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 16,
    parameter int P_WIDTH   = 32,
    parameter bit A_SIGNED  = 1'b0,
    parameter bit B_SIGNED  = 1'b1,
    parameter int NUM_STAGE = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ce,
`ifdef MD5_HASHER_MUL_ACC_EN
    input  logic               acc_en,
    input  logic               acc_clr,
`endif
    input  logic               in_valid,
    input  logic [A_WIDTH-1:0] din0,
    input  logic [B_WIDTH-1:0] din1,
    output logic               out_valid,
    output logic [P_WIDTH-1:0] dout
);

    generate
        if (NUM_STAGE < MUL_MIN_STAGE || NUM_STAGE > MUL_MAX_STAGE) begin : gen_bad_stage
            $fatal(1, "md5_hasher_mul_pipe: NUM_STAGE out of range");
        end
    endgenerate

    localparam int FULL_W = mul_full_width(A_WIDTH, B_WIDTH);
    // Multiply at whichever is wider: the exact product width, or P_WIDTH.
    // Wider than exact gives the sign extension for free; the low P_WIDTH
    // bits of it give the wrap case.
    localparam int MUL_W  = (FULL_W > P_WIDTH) ? FULL_W : P_WIDTH;

`ifdef MD5_HASHER_MUL_ACC_EN
    localparam int SB_W = 3;   // {acc_clr, acc_en, valid}
    logic [SB_W-1:0] sb_in;
    assign sb_in = {acc_clr, acc_en, in_valid};
`else
    localparam int SB_W = 1;   // {valid}
    logic [SB_W-1:0] sb_in;
    assign sb_in = in_valid;
`endif

    // Stage 1: operand registers, loaded on every enabled cycle.
    logic [A_WIDTH-1:0] din0_q;
    logic [B_WIDTH-1:0] din1_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            din0_q <= '0;
            din1_q <= '0;
        end else if (ce) begin
            din0_q <= din0;
            din1_q <= din1;
        end
    end

    // One-bit extension per operand, then a signed multiply.
    logic signed [A_WIDTH:0]   a_ext;
    logic signed [B_WIDTH:0]   b_ext;
    logic signed [MUL_W-1:0]   a_mul;
    logic signed [MUL_W-1:0]   b_mul;
    logic        [P_WIDTH-1:0] prod_d;

    assign a_ext  = {A_SIGNED & din0_q[A_WIDTH-1], din0_q};
    assign b_ext  = {B_SIGNED & din1_q[B_WIDTH-1], din1_q};
    assign a_mul  = MUL_W'(a_ext);
    assign b_mul  = MUL_W'(b_ext);
    assign prod_d = P_WIDTH'(a_mul * b_mul);

    // Stage 2: product register.
    logic [P_WIDTH-1:0] prod_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            prod_q <= '0;
        end else if (ce) begin
            prod_q <= prod_d;
        end
    end

    // Stages 3..NUM_STAGE: plain delay, left for the tool to retime into the DSP.
    logic [P_WIDTH-1:0] prod_pipe;

    generate
        if (NUM_STAGE > 2) begin : gen_prod_dly
            md5_hasher_delay_line #(
                .WIDTH (P_WIDTH),
                .DEPTH (NUM_STAGE - 2)
            ) u_prod_dly (
                .clk   (clk),
                .reset (reset),
                .ce    (ce),
                .din   (prod_q),
                .dout  (prod_pipe)
            );
        end else begin : gen_prod_nodly
            assign prod_pipe = prod_q;
        end
    endgenerate

    // Valid bit (and accumulate controls) ride alongside the data, stage for stage.
    logic [SB_W-1:0] sb_pipe;

    md5_hasher_delay_line #(
        .WIDTH (SB_W),
        .DEPTH (NUM_STAGE)
    ) u_vld_dly (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .din   (sb_in),
        .dout  (sb_pipe)
    );

`ifdef MD5_HASHER_MUL_ACC_EN
    logic [P_WIDTH-1:0] acc_q;
    logic [P_WIDTH-1:0] acc_d;
    logic               acc_vld_q;

    // Invalid slots leave the accumulator untouched; the sum wraps naturally.
    always_comb begin
        acc_d = acc_q;
        if (sb_pipe[0]) begin
            if (sb_pipe[1]) begin
                acc_d = (sb_pipe[2] ? '0 : acc_q) + prod_pipe;
            end else begin
                acc_d = prod_pipe;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q     <= '0;
            acc_vld_q <= 1'b0;
        end else if (ce) begin
            acc_q     <= acc_d;
            acc_vld_q <= sb_pipe[0];
        end
    end

    assign dout      = acc_q;
    assign out_valid = acc_vld_q;
`else
    assign dout      = prod_pipe;
    assign out_valid = sb_pipe[0];
`endif

endmodule
